// File: rtl/btn_scan_pkg.sv
// btn_scan_pkg: event codes and scan FSM states shared by the button scanner.
// Used by btn_scan_ctrl and its testbench.
package btn_scan_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WAIT
    } scan_state_t;

    function automatic logic [1:0] evt_code(
        input logic level,
        input logic rep
    );
        if (rep) begin
            return EVT_REPEAT;
        end
        if (level) begin
            return EVT_RELEASE;
        end
        return EVT_PRESS;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: scan prescaler, one tick every TICK_DIV clocks while enabled.
// The count is parked at zero whenever enable is low.
module scan_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic          at_tc;

    assign at_tc = (pre_q == TC);
    assign tick  = enable && at_tc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else if (!enable || at_tc) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: one shared debounce engine scanning N_BTN buttons per tick.
// Define BTN_REPEAT_EN to add per-button auto-repeat events.
module btn_scan_ctrl #(
    parameter int N_BTN        = 8,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 16,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_level,
    output logic [N_BTN-1:0]         press_pulse,
    output logic [N_BTN-1:0]         release_pulse,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [1:0]               evt_type,
    output logic                     overrun
);

    import btn_scan_pkg::*;

    localparam int IDW = $clog2(N_BTN);
    localparam int CW  = $clog2(STABLE_TICKS);
    localparam logic [IDW-1:0] LAST = IDW'(N_BTN - 1);

    if (N_BTN < 2 || N_BTN > 32 || TICK_DIV < N_BTN + 2 ||
        STABLE_TICKS < 2 || REPEAT_RATE >= REPEAT_DELAY) begin : g_bad_cfg
        $error("btn_scan_ctrl: illegal parameter set");
    end

    logic [N_BTN-1:0] meta_q;
    logic [N_BTN-1:0] sync_q;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [CW-1:0]    cnt_q [N_BTN];

    logic             evt_valid_q;
    logic [IDW-1:0]   evt_id_q;
    logic [1:0]       evt_type_q;
    logic             overrun_q;

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [IDW-1:0]   idx_q;
    logic [IDW-1:0]   idx_d;

    logic             tick;
    logic             cur_sync;
    logic             cur_level;
    logic [CW-1:0]    cur_cnt;
    logic [CW-1:0]    cnt_new;
    logic             differs;
    logic             stable_hit;
    logic             rep_hit;
    logic             evt_due;
    logic             slot_free;
    logic             commit;
    logic             load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    always_comb begin
        cur_sync   = sync_q[idx_q];
        cur_level  = level_q[idx_q];
        cur_cnt    = cnt_q[idx_q];
        differs    = cur_sync ^ cur_level;
        stable_hit = differs && (int'(cur_cnt) + 1 == STABLE_TICKS);
        cnt_new    = '0;
        if (differs && !stable_hit) begin
            cnt_new = cur_cnt + 1'b1;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [HW-1:0] hold_q [N_BTN];
    logic [HW-1:0] cur_hold;
    logic [HW-1:0] hold_new;

    // hold freezes while a release is being debounced
    always_comb begin
        cur_hold = hold_q[idx_q];
        hold_new = cur_hold;
        rep_hit  = 1'b0;
        if (!cur_level || stable_hit) begin
            hold_new = '0;
        end else if (!differs) begin
            if (int'(cur_hold) + 1 == REPEAT_DELAY) begin
                rep_hit  = 1'b1;
                hold_new = RELOAD;
            end else begin
                hold_new = cur_hold + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
        end else if (commit) begin
            hold_q[idx_q] <= hold_new;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    assign evt_due   = stable_hit || rep_hit;
    assign slot_free = !evt_valid_q || evt_ready;
    assign load      = commit && evt_due;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // WAIT reprocesses idx in the very cycle the slot is accepted
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN, ST_WAIT: begin
                if (state_q == ST_SCAN || evt_ready) begin
                    if (evt_due && !slot_free) begin
                        state_d = ST_WAIT;
                    end else begin
                        commit = 1'b1;
                        if (idx_q == LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_SCAN;
                            idx_d   = idx_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= EVT_PRESS;
            overrun_q   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            press_q   <= '0;
            release_q <= '0;
            if (tick && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            if (commit) begin
                cnt_q[idx_q] <= cnt_new;
            end
            if (commit && stable_hit) begin
                level_q[idx_q] <= !cur_level;
                if (cur_level) begin
                    release_q[idx_q] <= 1'b1;
                end else begin
                    press_q[idx_q] <= 1'b1;
                end
            end
            if (load) begin
                evt_valid_q <= 1'b1;
                evt_id_q    <= idx_q;
                evt_type_q  <= evt_code(cur_level, rep_hit);
            end else if (evt_ready) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign evt_valid     = evt_valid_q;
    assign evt_id        = evt_id_q;
    assign evt_type      = evt_type_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// tb_btn_scan_ctrl: scoreboard bench for btn_scan_ctrl, directed plus random.
// Build with BTN_REPEAT_EN defined to exercise the auto-repeat path instead.
`timescale 1ns/1ps
module tb_btn_scan_ctrl;

    import btn_scan_pkg::*;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int ST = 3;
    localparam int RD = 4;
    localparam int RR = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic         evt_ready = 1'b0;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [1:0]   evt_type;
    logic         overrun;

    btn_scan_ctrl #(
        .N_BTN        (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_id        (evt_id),
        .evt_type      (evt_type),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] typ;
    } ev_t;

    ev_t          exp_q[$];
    int           pop_cyc[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    bit           per_btn = 1'b0;
    bit           rnd_ready = 1'b0;
    int           press_exp[N];
    int           rel_exp[N];
    int           press_seen[N];
    int           rel_seen[N];
    logic [N-1:0] settled;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, expected none", name, act);
    endtask

    task automatic push(input int id, input logic [1:0] typ);
        ev_t e;
        e.id  = 2'(id);
        e.typ = typ;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) evt_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_valid(input string name, input int lim);
        int k;
        k = 0;
        while (!evt_valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (!evt_valid) flag(name, 32'(k));
    endtask

    // monitor: every handshake seen at the falling edge is scored
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (press_pulse[i]) press_seen[i]++;
                if (release_pulse[i]) rel_seen[i]++;
            end
            if (evt_valid && evt_ready) begin
                int k;
                k = -1;
                for (int j = 0; j < exp_q.size(); j++) begin
                    if (k < 0 && (!per_btn || exp_q[j].id == evt_id)) k = j;
                end
                if (k < 0) begin
                    flag("evt_unexpected", {28'd0, evt_id, evt_type});
                end else begin
                    check("evt_id", 32'(evt_id), 32'(exp_q[k].id));
                    check("evt_type", 32'(evt_type), 32'(exp_q[k].typ));
                    exp_q.delete(k);
                end
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic reset_checks();
        step(3);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_press", 32'(press_pulse), 32'h0);
        check("rst_release", 32'(release_pulse), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_id", 32'(evt_id), 32'h0);
        check("rst_type", 32'(evt_type), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
    endtask

    initial begin
        int n;
        logic [N-1:0] nv;
        enable = 1'b1;
        evt_ready = 1'b1;
`ifdef BTN_REPEAT_EN
        btn_raw = '0;
        reset_checks();
        reset_n = 1'b1;
        step(40);
        pop_cyc.delete();
        btn_raw = 4'b1000;
        push(3, EVT_PRESS);
        push(3, EVT_REPEAT);
        push(3, EVT_REPEAT);
        push(3, EVT_REPEAT);
        n = 0;
        while (pop_cyc.size() < 4 && n < 300) begin
            step(1);
            n++;
        end
        btn_raw = '0;
        push(3, EVT_RELEASE);
        step(120);
        check("rep_count", 32'(pop_cyc.size()), 32'd5);
        if (pop_cyc.size() >= 4) begin
            check("rep_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'(4 * TD));
            check("rep_gap2", 32'(pop_cyc[2] - pop_cyc[0]), 32'(6 * TD));
            check("rep_gap3", 32'(pop_cyc[3] - pop_cyc[0]), 32'(8 * TD));
        end
        check("rep_left", 32'(exp_q.size()), 32'd0);
`else
        btn_raw = 4'hF;
        reset_checks();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) push(i, EVT_PRESS);
        step(20);
        check("lvl_scan2", 32'(btn_level), 32'h0);
        step(10);
        check("lvl_scan3", 32'(btn_level), 32'hF);
        check("press_left", 32'(exp_q.size()), 32'd0);

        btn_raw = '0;
        for (int i = 0; i < N; i++) push(i, EVT_RELEASE);
        step(60);
        check("lvl_released", 32'(btn_level), 32'h0);

        btn_raw = 4'b0010;
        step(16);
        btn_raw = '0;
        step(60);
        check("glitch_lvl", 32'(btn_level[1]), 32'h0);

        btn_raw = 4'b0100;
        push(2, EVT_PRESS);
        step(50);
        check("lvl_btn2", 32'(btn_level), 32'h4);
        btn_raw = '0;
        push(2, EVT_RELEASE);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (release_pulse[2]) n++;
        end
        check("rel_pulse_len", 32'(n), 32'd1);
        check("no_overrun", 32'(overrun), 32'h0);

        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        btn_raw = 4'b0101;
        push(0, EVT_PRESS);
        push(2, EVT_PRESS);
        wait_valid("bp_valid_timeout", 100);
        step(12);
        check("bp_state", 32'(dut.state_q), 32'(ST_WAIT));
        check("bp_valid", 32'(evt_valid), 32'h1);
        check("bp_id0", 32'(evt_id), 32'h0);
        check("bp_overrun", 32'(overrun), 32'h1);
        @(posedge clk);
        #1;
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_valid", 32'(evt_valid), 32'h1);
        check("bp_next_id", 32'(evt_id), 32'h2);
        step(30);

        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        btn_raw = 4'hF;
        push(1, EVT_PRESS);
        push(3, EVT_PRESS);
        wait_valid("rw_valid_timeout", 100);
        step(3);
        check("rw_state", 32'(dut.state_q), 32'(ST_WAIT));
        check("rw_cnt3", 32'(dut.cnt_q[3]), 32'd2);
        reset_n = 1'b0;
        #1;
        check("rw_valid_async", 32'(evt_valid), 32'h0);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            check("rw_cnt_clr", 32'(dut.cnt_q[i]), 32'd0);
        end
        check("rw_overrun", 32'(overrun), 32'h0);
        check("rw_level", 32'(btn_level), 32'h0);

        btn_raw = '0;
        step(2);
        per_btn = 1'b1;
        settled = '0;
        for (int i = 0; i < N; i++) begin
            press_exp[i] = 0;
            rel_exp[i] = 0;
            press_seen[i] = 0;
            rel_seen[i] = 0;
        end
        reset_n = 1'b1;
        rnd_ready = 1'b1;
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                nv = settled;
                nv[$urandom_range(0, N - 1)] ^= 1'b1;
                btn_raw = nv;
                step($urandom_range(1, 8));
                btn_raw = settled;
                step(20);
            end
            nv = settled ^ N'($urandom_range(0, (1 << N) - 1));
            btn_raw = nv;
            for (int i = 0; i < N; i++) begin
                if (nv[i] != settled[i]) begin
                    push(i, settled[i] ? EVT_RELEASE : EVT_PRESS);
                    if (settled[i]) rel_exp[i]++;
                    else press_exp[i]++;
                end
            end
            settled = nv;
            step(120);
        end
        rnd_ready = 1'b0;
        evt_ready = 1'b1;
        step(150);
        check("rnd_left", 32'(exp_q.size()), 32'd0);
        check("rnd_level", 32'(btn_level), 32'(settled));
        for (int i = 0; i < N; i++) begin
            check("rnd_press_pulses", 32'(press_seen[i]), 32'(press_exp[i]));
            check("rnd_rel_pulses", 32'(rel_seen[i]), 32'(rel_exp[i]));
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_scan_ctrl.md
# btn_scan_ctrl

Scan controller for the front-panel button bank. It time-multiplexes one debounce engine across `N_BTN` raw inputs and paces the scanning with a shared tick prescaler. Each debounced edge becomes an event (press, release, optional auto-repeat) on a single valid/ready event port consumed by the panel/menu logic. It also drives the debounced level and one-cycle edge pulses per button.

## Interface
- `N_BTN`, 8, number of buttons scanned (2..32)
- `TICK_DIV`, 1000, clk cycles per scan tick; must be ≥ `N_BTN`+2
- `STABLE_TICKS`, 16, consecutive differing samples required to accept a change (≥2)
- `REPEAT_DELAY`, 500, ticks held before first repeat (macro only)
- `REPEAT_RATE`, 100, ticks between repeats (macro only; < `REPEAT_DELAY`)

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  permits new scans
- `btn_raw`  in  N_BTN  raw active-high button inputs, asynchronous
- `btn_level`  out  N_BTN  debounced levels
- `press_pulse`  out  N_BTN  one-cycle pulse on debounced 0→1
- `release_pulse`  out  N_BTN  one-cycle pulse on debounced 1→0
- `evt_valid`  out  1  event available
- `evt_ready`  in  1  consumer accepts event
- `evt_id`  out  $clog2(N_BTN)  button index of event
- `evt_type`  out  2  00 press, 01 release, 10 repeat
- `overrun`  out  1  sticky: a tick arrived while not IDLE

## Operation
- 2-FF synchronizer on all `btn_raw` bits → `sync`.
- Prescaler 0..`TICK_DIV`-1. Asserts `tick` at terminal count while `enable`=1. Held at 0 while `enable`=0.
- FSM states: IDLE, SCAN, WAIT.
  - IDLE: `tick` → SCAN, idx=0.
  - SCAN: process button idx (one per cycle). idx=`N_BTN`-1 processed → IDLE.
  - WAIT: entered when an event is due and `evt_valid`=1 with `evt_ready`=0. Holds idx with no state update. On `evt_ready` → SCAN and reprocess idx.
- Per-button processing:
  - `sync[idx]`==`btn_level[idx]`: `cnt[idx]`←0.
  - `sync[idx]`!=`btn_level[idx]` and `cnt`+1<`STABLE_TICKS`: `cnt`++.
  - `sync[idx]`!=`btn_level[idx]` and `cnt`+1==`STABLE_TICKS`: toggle level, `cnt`←0, load event, pulse. Only if the event slot is free; otherwise WAIT.
- `cnt` width: $clog2(`STABLE_TICKS`).
- Event slot frees when `evt_ready`=1. The slot may be refilled in the same cycle it is accepted.
- `enable` falling mid-scan: the current scan completes; no further scans.
- `tick` while SCAN/WAIT: the tick is dropped and `overrun`←1. It clears only on reset.

## Timing
- Reset: `btn_level`, `press_pulse`, `release_pulse`, `evt_valid`, `evt_id`, `evt_type`, `overrun`, all `cnt` = 0; FSM IDLE; prescaler 0.
- Event registered: `evt_valid` and the pulse rise the cycle after the processing cycle.
- Raw edge to event: 2 sync cycles + up to `STABLE_TICKS` ticks + (idx+1) cycles.
- `evt_id`/`evt_type` stable while `evt_valid`=1 and `evt_ready`=0.
- Same-tick changes on several buttons emit events in ascending idx order.

## Configuration
- `BTN_REPEAT_EN` defined:
  - Per-button `hold` counter increments each scan while `btn_level`=1 and `sync`=1.
  - On reaching `REPEAT_DELAY`: emit type 10 (subject to WAIT) and reload `hold`←`REPEAT_DELAY`−`REPEAT_RATE`.
  - `hold`←0 on release.
- Undefined: no `hold` registers; `evt_type` is never 10.

## Structure
- Package `btn_scan_pkg`: `evt_type` constants (`EVT_PRESS`, `EVT_RELEASE`, `EVT_REPEAT`) and FSM state enum.
- Sub-module `scan_tick_gen`: prescaler plus `enable` gating, outputs `tick`.

## Test plan
Common parameters: `N_BTN`=4, `TICK_DIV`=8, `STABLE_TICKS`=3, `evt_ready`=1 unless noted.
- Reset:
  - `reset_n`=0 with `btn_raw`=4'hF → all outputs 0.
  - After release → press events ids 0,1,2,3 in order. `btn_level`=4'hF after 3rd scan.
- Glitch: `btn_raw[1]`=1 for 16 cycles then 0 → no event; `btn_level[1]` stays 0.
- Release: after btn 2 pressed, drop `btn_raw[2]` → `evt_type`=01 `evt_id`=2 after 3 scans; `release_pulse[2]` high exactly 1 cycle.
- Backpressure: `evt_ready`=0, press btns 0 and 2 together.
  - id0 press held valid; FSM in WAIT; `overrun`=1 after next tick.
  - `evt_ready`=1 → id0 accepted, id2 press presented the following cycle.
- Reset mid-WAIT: `reset_n`=0 → `evt_valid` falls immediately (async); all `cnt` cleared.
- Repeat (`BTN_REPEAT_EN`, `REPEAT_DELAY`=4, `REPEAT_RATE`=2): hold btn 3 → repeat events 4, 6, 8 scans after the press event; none after release.
